// File: rtl/riscv_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : riscv_multicycle_control
// Description : Multi-cycle RV32I control sequencer. Steps each instruction
//               through FETCH/DECODE/EXEC/MEM/WB using a ready handshake to a
//               shared memory, with a memory-timeout watchdog, an
//               illegal-opcode trap and a retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_multicycle_control #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             Branch,
    output logic             Jump,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             MemToReg,
    output logic             ALUSrc,
    output logic [1:0]       ALUOp,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Final watchdog value at which a still-missing mem_ready means timeout
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [6:0]      op_q;
    logic [TO_W-1:0] watchdog;
    logic            retire;
    logic [1:0]      next_cause;
    logic            opcode_legal;
    logic            timed_out;

    assign opcode_legal = (opcode == OP_R)      || (opcode == OP_I)      ||
                          (opcode == OP_LOAD)   || (opcode == OP_STORE)  ||
                          (opcode == OP_BRANCH) || (opcode == OP_LUI)    ||
                          (opcode == OP_AUIPC)  || (opcode == OP_JAL)    ||
                          (opcode == OP_JALR);

    assign timed_out = !mem_ready && (watchdog == TO_LAST);
    assign trap      = (state == S_TRAP);

    // State, latched opcode, watchdog, retire counter and trap cause
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_FETCH;
            op_q       <= 7'd0;
            watchdog   <= '0;
            instret    <= '0;
            trap_cause <= 2'b00;
        end else begin
            state <= next_state;
            if (state == S_DECODE) begin
                op_q <= opcode;
            end
            // Count only consecutive unanswered cycles of the same request
            if ((state == S_FETCH || state == S_MEM) && !mem_ready &&
                next_state == state) begin
                watchdog <= watchdog + 1'b1;
            end else begin
                watchdog <= '0;
            end
            if (retire) begin
                instret <= instret + 1'b1;
            end
            if (state != S_TRAP && next_state == S_TRAP) begin
                trap_cause <= next_cause;
            end
        end
    end

    // Next-state and datapath enables decoded from state and latched opcode
    always_comb begin
        next_state = state;
        retire     = 1'b0;
        next_cause = 2'b00;
        Branch     = 1'b0;
        Jump       = 1'b0;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        MemToReg   = 1'b0;
        ALUSrc     = 1'b0;
        ALUOp      = 2'b00;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    next_state = S_DECODE;
                end else if (timed_out) begin
                    next_state = S_TRAP;
                    next_cause = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (opcode_legal) begin
                    next_state = S_EXEC;
                end else begin
                    next_state = S_TRAP;
                    next_cause = CAUSE_ILLEGAL;
                end
            end
            S_EXEC: begin
                next_state = S_WB;
                case (op_q)
                    OP_I: begin
                        ALUSrc = 1'b1;
                    end
                    OP_LOAD, OP_STORE: begin
                        ALUSrc     = 1'b1;
                        ALUOp      = 2'b10;
                        next_state = S_MEM;
                    end
                    OP_BRANCH: begin
                        Branch     = 1'b1;
                        ALUOp      = 2'b01;
                        retire     = 1'b1;
                        next_state = S_FETCH;
                    end
                    OP_LUI, OP_AUIPC: begin
                        ALUSrc = 1'b1;
                        ALUOp  = 2'b11;
                    end
                    OP_JAL, OP_JALR: begin
                        Jump   = 1'b1;
                        ALUSrc = 1'b1;
                        ALUOp  = 2'b11;
                    end
                    default: begin
                        ALUOp = 2'b00;
                    end
                endcase
            end
            S_MEM: begin
                IorD = 1'b1;
                if (op_q == OP_LOAD) begin
                    MemRead = 1'b1;
                end else begin
                    MemWrite = 1'b1;
                end
                if (mem_ready) begin
                    if (op_q == OP_LOAD) begin
                        next_state = S_WB;
                    end else begin
                        retire     = 1'b1;
                        next_state = S_FETCH;
                    end
                end else if (timed_out) begin
                    next_state = S_TRAP;
                    next_cause = CAUSE_TIMEOUT;
                end
            end
            S_WB: begin
                RegWrite   = 1'b1;
                MemToReg   = (op_q == OP_LOAD);
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            default: begin
                next_state = S_TRAP;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_multicycle_control
// Description : Directed self-checking bench for riscv_multicycle_control.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_multicycle_control;

    localparam int MEM_TIMEOUT = 4;
    localparam int TO_W        = 3;
    localparam int CNT_W       = 4;

    localparam logic [6:0] ADDI = 7'b0010011;
    localparam logic [6:0] RTYP = 7'b0110011;
    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] LUI  = 7'b0110111;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] BAD  = 7'b1111111;

    // {Branch,Jump,PCWrite,IRWrite,IorD,MemRead,MemWrite,RegWrite,MemToReg,ALUSrc,ALUOp}
    localparam logic [11:0] C_NONE  = 12'b0000_0000_0000;
    localparam logic [11:0] C_FWAIT = 12'b0000_0100_0000;
    localparam logic [11:0] C_FRDY  = 12'b0011_0100_0000;
    localparam logic [11:0] C_EI    = 12'b0000_0000_0100;
    localparam logic [11:0] C_ER    = 12'b0000_0000_0000;
    localparam logic [11:0] C_ELS   = 12'b0000_0000_0110;
    localparam logic [11:0] C_EBR   = 12'b1000_0000_0001;
    localparam logic [11:0] C_EU    = 12'b0000_0000_0111;
    localparam logic [11:0] C_EJ    = 12'b0100_0000_0111;
    localparam logic [11:0] C_MLD   = 12'b0000_1100_0000;
    localparam logic [11:0] C_MST   = 12'b0000_1010_0000;
    localparam logic [11:0] C_WALU  = 12'b0000_0001_0000;
    localparam logic [11:0] C_WLD   = 12'b0000_0001_1000;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [6:0]       opcode = 7'd0;
    logic             mem_ready = 1'b0;
    logic             Branch, Jump, PCWrite, IRWrite, IorD, MemRead, MemWrite;
    logic             RegWrite, MemToReg, ALUSrc, trap;
    logic [1:0]       ALUOp, trap_cause;
    logic [CNT_W-1:0] instret;
    logic [11:0]      ctl;

    int errors = 0;
    int checks = 0;

    assign ctl = {Branch, Jump, PCWrite, IRWrite, IorD, MemRead, MemWrite,
                  RegWrite, MemToReg, ALUSrc, ALUOp};

    always #5 clk = ~clk;

    riscv_multicycle_control #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TO_W       (TO_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .Branch    (Branch),
        .Jump      (Jump),
        .PCWrite   (PCWrite),
        .IRWrite   (IRWrite),
        .IorD      (IorD),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .RegWrite  (RegWrite),
        .MemToReg  (MemToReg),
        .ALUSrc    (ALUSrc),
        .ALUOp     (ALUOp),
        .trap      (trap),
        .trap_cause(trap_cause),
        .instret   (instret)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check enables, advance past the next edge
    task automatic step(input string tag, input logic rdy, input logic [6:0] op,
                        input logic [11:0] exp);
        mem_ready = rdy;
        opcode    = op;
        #1;
        check(tag, {20'd0, ctl}, {20'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset     = 1'b1;
        mem_ready = 1'b0;
        opcode    = BAD;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        #1;
        check("rst_ctl", {20'd0, ctl}, {20'd0, C_FWAIT});
        check("rst_instret", 32'(instret), 32'd0);
        check("rst_trap", {31'd0, trap}, 32'd0);
        check("rst_cause", {30'd0, trap_cause}, 32'd0);

        // ADDI with ready high; opcode only valid in DECODE to prove latching
        step("addi_f", 1'b1, BAD, C_FRDY);
        step("addi_d", 1'b1, ADDI, C_NONE);
        step("addi_e", 1'b1, BAD, C_EI);
        check("addi_cnt_pre", 32'(instret), 32'd0);
        step("addi_w", 1'b1, BAD, C_WALU);
        check("addi_cnt", 32'(instret), 32'd1);

        // LW with 3 wait cycles in MEM
        step("lw_f", 1'b1, BAD, C_FRDY);
        step("lw_d", 1'b1, LW, C_NONE);
        step("lw_e", 1'b1, BAD, C_ELS);
        for (int i = 0; i < 3; i++) step("lw_mwait", 1'b0, BAD, C_MLD);
        step("lw_mrdy", 1'b1, BAD, C_MLD);
        step("lw_w", 1'b0, BAD, C_WLD);
        check("lw_cnt", 32'(instret), 32'd2);

        // SW, R-type, LUI, JAL, BEQ with ready high
        step("sw_f", 1'b1, BAD, C_FRDY);
        step("sw_d", 1'b1, SW, C_NONE);
        step("sw_e", 1'b1, BAD, C_ELS);
        step("sw_m", 1'b1, BAD, C_MST);
        check("sw_cnt", 32'(instret), 32'd3);
        step("r_f", 1'b1, BAD, C_FRDY);
        step("r_d", 1'b1, RTYP, C_NONE);
        step("r_e", 1'b1, BAD, C_ER);
        step("r_w", 1'b1, BAD, C_WALU);
        step("lui_f", 1'b1, BAD, C_FRDY);
        step("lui_d", 1'b1, LUI, C_NONE);
        step("lui_e", 1'b1, BAD, C_EU);
        step("lui_w", 1'b1, BAD, C_WALU);
        step("jal_f", 1'b1, BAD, C_FRDY);
        step("jal_d", 1'b1, JAL, C_NONE);
        step("jal_e", 1'b1, BAD, C_EJ);
        step("jal_w", 1'b1, BAD, C_WALU);
        check("mix_cnt", 32'(instret), 32'd6);
        step("beq_f", 1'b1, BAD, C_FRDY);
        step("beq_d", 1'b1, BEQ, C_NONE);
        step("beq_e", 1'b1, BAD, C_EBR);
        check("beq_cnt", 32'(instret), 32'd7);
        step("after_beq_f", 1'b0, BAD, C_FWAIT);

        // Illegal opcode trap, sticky against mem_ready pulses
        do_reset();
        step("ill_f", 1'b1, BAD, C_FRDY);
        step("ill_d", 1'b1, BAD, C_NONE);
        check("ill_trap", {31'd0, trap}, 32'd1);
        check("ill_cause", {30'd0, trap_cause}, 32'd1);
        step("ill_hold0", 1'b1, ADDI, C_NONE);
        step("ill_hold1", 1'b0, ADDI, C_NONE);
        step("ill_hold2", 1'b1, ADDI, C_NONE);
        check("ill_trap_hold", {31'd0, trap}, 32'd1);
        check("ill_cnt", 32'(instret), 32'd0);

        // Fetch timeout: request held exactly MEM_TIMEOUT cycles
        do_reset();
        for (int i = 0; i < MEM_TIMEOUT; i++) step("to_fwait", 1'b0, BAD, C_FWAIT);
        check("to_trap", {31'd0, trap}, 32'd1);
        check("to_cause", {30'd0, trap_cause}, 32'd2);
        step("to_hold", 1'b1, ADDI, C_NONE);
        check("to_cause_hold", {30'd0, trap_cause}, 32'd2);

        // Ready in the final cycle wins over timeout
        do_reset();
        for (int i = 0; i < MEM_TIMEOUT - 1; i++) step("late_fwait", 1'b0, BAD, C_FWAIT);
        step("late_frdy", 1'b1, BAD, C_FRDY);
        check("late_notrap", {31'd0, trap}, 32'd0);
        step("late_d", 1'b0, ADDI, C_NONE);
        step("late_e", 1'b0, BAD, C_EI);

        // Watchdog restarts on a new request: MEM wait of MEM_TIMEOUT-1 after slow fetch
        do_reset();
        for (int i = 0; i < MEM_TIMEOUT - 1; i++) step("wd_fwait", 1'b0, BAD, C_FWAIT);
        step("wd_frdy", 1'b1, BAD, C_FRDY);
        step("wd_d", 1'b1, LW, C_NONE);
        step("wd_e", 1'b1, BAD, C_ELS);
        for (int i = 0; i < MEM_TIMEOUT - 1; i++) step("wd_mwait", 1'b0, BAD, C_MLD);
        step("wd_mrdy", 1'b1, BAD, C_MLD);
        check("wd_notrap", {31'd0, trap}, 32'd0);
        step("wd_w", 1'b0, BAD, C_WLD);

        // Counter wrap over 16 branches
        do_reset();
        for (int n = 1; n <= 16; n++) begin
            step("wrap_f", 1'b1, BAD, C_FRDY);
            step("wrap_d", 1'b1, BEQ, C_NONE);
            step("wrap_e", 1'b1, BAD, C_EBR);
            if (n == 15) check("wrap_cnt15", 32'(instret), 32'd15);
        end
        check("wrap_cnt0", 32'(instret), 32'd0);

        // Asynchronous reset during the MEM cycle of a store
        do_reset();
        step("rsw_f", 1'b1, BAD, C_FRDY);
        step("rsw_d", 1'b1, SW, C_NONE);
        step("rsw_e", 1'b1, BAD, C_ELS);
        mem_ready = 1'b0;
        #1;
        check("rsw_m", {20'd0, ctl}, {20'd0, C_MST});
        #1;
        reset = 1'b1;
        #1;
        check("rsw_async", {20'd0, ctl}, {20'd0, C_FWAIT});
        check("rsw_cnt", 32'(instret), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("rsw_refetch", 1'b1, BAD, C_FRDY);
        check("rsw_cnt2", 32'(instret), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
